// File: rtl/mips_mem_arbiter.sv
// Three-port arbiter in front of the pipe_MIPS32 single-port RAM (loader, MEM stage, IF stage).
// Includes a halt handshake that drains core reads and hands the RAM to the loader.
module mips_mem_arbiter #(
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [95:0]     wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [31:0]     rdata,
    input  logic            halt_req,
    output logic            halted,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    output logic [1:0]      dbg_state
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DEBUG = 2'd2
    } state_t;

    // Handshake: a requester holds req[i] (with we/addr/wdata stable) until it
    // sees gnt[i] in the same cycle; the access then belongs to the arbiter and
    // a read answers with a single rvalid[i] pulse two cycles later.
    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic [2:0]      rd_tag;
    logic            promote;
    logic [AW-1:0]   sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_we;

    assign promote   = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    assign rdata     = mem_rdata;
    assign dbg_state = state;

    always_comb begin
        gnt = 3'b000;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (promote && req[2])  gnt = 3'b100;
                    else if (req[1])        gnt = 3'b010;
                    else if (req[2])        gnt = 3'b100;
                    else if (req[0])        gnt = 3'b001;
                end
                DEBUG: begin
                    if (req[0])             gnt = 3'b001;
                end
                default: gnt = 3'b000;
            endcase
        end
    end

    always_comb begin
        sel_addr  = addr[0 +: AW];
        sel_wdata = wdata[0 +: 32];
        sel_we    = we[0];
        if (gnt[1]) begin
            sel_addr  = addr[AW +: AW];
            sel_wdata = wdata[32 +: 32];
            sel_we    = we[1];
        end else if (gnt[2]) begin
            sel_addr  = addr[2*AW +: AW];
            sel_wdata = wdata[64 +: 32];
            sel_we    = we[2];
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            starve_cnt <= '0;
            rd_tag     <= 3'b000;
            rvalid     <= 3'b000;
            halted     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= |gnt;
            mem_we <= (|gnt) && sel_we;
            if (|gnt) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            // Read tag rides alongside the RAM latency so rvalid lines up with mem_rdata.
            rd_tag <= sel_we ? 3'b000 : gnt;
            rvalid <= rd_tag;

            case (state)
                RUN: begin
                    if (!req[2] || gnt[2])
                        starve_cnt <= '0;
                    else if (starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + 1'b1;
                    if (halt_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state <= RUN;
                    end else if (rd_tag == 3'b000 && rvalid == 3'b000) begin
                        state  <= DEBUG;
                        halted <= 1'b1;
                    end
                end
                DEBUG: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
